// File: rtl/mux8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package mux8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, modulo 8.
module rr_pick8
   import mux8_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] idx_o,
   output logic             any_o
);

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]   enc;

   // Rotating right by ptr puts the highest-priority requester at bit 0.
   assign req_dbl = {req_i, req_i};
   assign req_rot = req_dbl[{1'b0, ptr_i} +: N_REQ];
   assign any_o   = |req_i;

   // Priority-encode the lowest set bit of the rotated vector.
   always_comb begin
      enc = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            enc = SEL_W'(i);
         end
      end
   end

   // Undo the rotation; 3-bit addition wraps modulo 8.
   assign idx_o = enc + ptr_i;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler driving the select of a shared 8-to-1 mux, with a dwell timeout
// per grant and one settle cycle between grants. All outputs are registered.
module mux8_rr_arbiter
   import mux8_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [N_REQ-1:0] iREQ,
   input  logic             iDONE,
   output logic [SEL_W-1:0] oSEL,
   output logic [N_REQ-1:0] oGNT,
   output logic             oVALID
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_MAX - 1);

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             valid_q, valid_d;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             grant_end;

   rr_pick8 u_pick (
      .req_i (iREQ),
      .ptr_i (ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Release on done, withdrawal of the owner's request, or dwell timeout.
   assign grant_end = iDONE | ~iREQ[sel_q] | (cnt_q == CntLast);

   // Next-state logic: arbitrate in idle, count dwell and watch for release in grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               state_d = StGrant;
               sel_d   = pick_idx;
               gnt_d   = N_REQ'(1) << pick_idx;
               valid_d = 1'b1;
               cnt_d   = '0;
               ptr_d   = pick_idx + SEL_W'(1);
            end
         end
         StGrant: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (grant_end) begin
               // oSEL deliberately keeps the last owner's index.
               state_d = StIdle;
               gnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
      end
   end

   assign oSEL   = sel_q;
   assign oGNT   = gnt_q;
   assign oVALID = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural scheduler model.
module tb_mux8_rr_arbiter;

   localparam int unsigned HOLD = 4;

   logic       iCLK = 1'b0;
   logic       iRST;
   logic [7:0] iREQ;
   logic       iDONE;
   logic [2:0] oSEL;
   logic [7:0] oGNT;
   logic       oVALID;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: current owner (-1 = none), cycles owned so far, next starting index, last select.
   int m_owner;
   int m_cnt;
   int m_ptr;
   int m_sel;

   int got[$];
   logic prev_valid;

   always #5 iCLK = ~iCLK;

   mux8_rr_arbiter #(
      .HOLD_MAX (HOLD)
   ) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iREQ   (iREQ),
      .iDONE  (iDONE),
      .oSEL   (oSEL),
      .oGNT   (oGNT),
      .oVALID (oVALID)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
      m_sel   = 0;
   endtask

   task automatic model_clock(input logic [7:0] req, input logic done);
      bit found;
      int k;
      if (m_owner < 0) begin
         found = 0;
         for (int i = 0; i < 8; i++) begin
            k = (m_ptr + i) % 8;
            if (!found && req[k]) begin
               found   = 1;
               m_owner = k;
               m_sel   = k;
               m_cnt   = 1;
               m_ptr   = (k + 1) % 8;
            end
         end
      end else if (done || !req[m_owner] || m_cnt >= int'(HOLD)) begin
         m_owner = -1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] exp_gnt;
      exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
      check_eq("sel", 32'(oSEL), 32'(m_sel));
      check_eq("gnt", 32'(oGNT), exp_gnt);
      check_eq("valid", 32'(oVALID), 32'(m_owner >= 0));
      check_eq("onehot0", 32'($onehot0(oGNT)), 32'd1);
      check_eq("valid_vs_gnt", 32'(oVALID), 32'(oGNT != 8'h00));
      check_eq("gnt_at_sel", 32'(oGNT[oSEL]), 32'(oVALID));
   endtask

   // One clock: drive inputs, let the edge happen, step the model, sample 1 ns later.
   task automatic cycle(input logic [7:0] req, input logic done);
      iREQ  = req;
      iDONE = done;
      @(posedge iCLK);
      model_clock(req, done);
      #1;
      check_outputs();
      if (oVALID && !prev_valid) got.push_back(int'(oSEL));
      prev_valid = oVALID;
   endtask

   task automatic do_reset();
      iREQ  = 8'h00;
      iDONE = 1'b0;
      iRST  = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge iCLK);
      @(negedge iCLK);
      iRST = 1'b0;
      prev_valid = 1'b0;
      got.delete();
   endtask

   initial begin
      int exp3[$];
      int exp4[$];
      logic [7:0] req;
      logic done;

      iRST = 1'b1;
      iREQ = 8'h00;
      iDONE = 1'b0;
      prev_valid = 1'b0;
      do_reset();

      // Single held request: 4-cycle grants with one idle cycle between.
      for (int c = 0; c < 10; c++) begin
         cycle(8'h04, 1'b0);
         check_eq("t2_valid", 32'(oVALID), 32'(c % 5 != 4));
         check_eq("t2_sel", 32'(oSEL), 32'd2);
      end

      // Async reset mid-grant clears outputs without a clock edge.
      #3;
      iRST = 1'b1;
      #1;
      check_eq("t1_gnt", 32'(oGNT), 32'h00);
      check_eq("t1_valid", 32'(oVALID), 32'd0);
      check_eq("t1_sel", 32'(oSEL), 32'd0);
      do_reset();

      // Fairness: all requesting, done every grant.
      for (int c = 0; c < 18; c++) cycle(8'hFF, 1'b1);
      exp3 = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      check_eq("t3_count", 32'(got.size()), 32'(exp3.size()));
      for (int i = 0; i < exp3.size() && i < got.size(); i++)
         check_eq("t3_order", 32'(got[i]), 32'(exp3[i]));

      // Wrap-around after a grant to 6.
      do_reset();
      cycle(8'h40, 1'b1);
      cycle(8'h40, 1'b1);
      for (int c = 0; c < 5; c++) cycle(8'h81, 1'b1);
      exp4 = '{6, 7, 0, 7};
      check_eq("t4_count", 32'(got.size()), 32'(exp4.size()));
      for (int i = 0; i < exp4.size() && i < got.size(); i++)
         check_eq("t4_order", 32'(got[i]), 32'(exp4[i]));

      // Withdraw during the second grant cycle.
      do_reset();
      cycle(8'h08, 1'b0);
      cycle(8'h08, 1'b0);
      check_eq("t5_held", 32'(oVALID), 32'd1);
      cycle(8'h00, 1'b0);
      check_eq("t5_release", 32'(oVALID), 32'd0);

      // Done coincides with timeout: one release, one idle cycle.
      do_reset();
      for (int c = 0; c < 4; c++) cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b1);
      check_eq("t6_release", 32'(oVALID), 32'd0);
      cycle(8'h10, 1'b0);
      check_eq("t6_regrant", 32'(oVALID), 32'd1);
      check_eq("t6_sel", 32'(oSEL), 32'd4);

      // Random traffic against the model.
      do_reset();
      req = 8'h00;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(3) == 0) req = 8'($urandom);
         done = ($urandom_range(3) == 0);
         cycle(req, done);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000 ns");
      $fatal(1);
   end

endmodule
